// File: rtl/cscv2_outport.sv
`default_nettype none
// ============================================================================
// Module   : cscv2_outport
// Purpose  : Memory-mapped byte output port for the CSCv2 core. Snoops core
//            RAM writes, pairs 4-bit writes to OUT_ADDR into bytes and queues
//            them in a first-word-fall-through FIFO that drains over a
//            valid/ready stream. The core never stalls; drops set overflow.
// Revision : 1.0 - initial release
// ============================================================================
module cscv2_outport #(
    parameter logic [7:0] OUT_ADDR   = 8'hFF,
    parameter logic [7:0] FLUSH_ADDR = 8'hFE,
    parameter int         DEPTH      = 8,
    parameter int         CW         = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ramwrite,
    input  logic [7:0]    address,
    input  logic [3:0]    data,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          pending,
    output logic          full,
    output logic          overflow,
    output logic [CW-1:0] count
);

    // Pointer width; DEPTH is a power of two so pointers wrap on their own.
    localparam int AW = CW - 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    // Byte storage, deliberately not reset.
    logic [7:0]    r_mem [DEPTH];

    logic [AW-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [AW-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [CW-1:0] r_count_q,  w_count_d;
    logic          r_pending_q, w_pending_d;
    logic          r_overflow_q, w_overflow_d;
    logic [3:0]    r_hold_q,   w_hold_d;

    logic          w_capture;
    logic          w_flush;
    logic          w_push_req;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_drop;
    logic [7:0]    w_wr_byte;

    // Decode the snooped write and decide push/pop/drop for this edge.
    always_comb begin
        w_capture  = ramwrite && (address == OUT_ADDR);
        w_flush    = ramwrite && (address == FLUSH_ADDR);
        w_empty    = (r_count_q == '0);
        w_full     = (r_count_q == C_DEPTH);
        w_pop      = !w_empty && out_ready;
        w_push_req = w_capture && r_pending_q;
        // A full FIFO still takes the byte if a slot frees on the same edge.
        w_push     = w_push_req && (!w_full || w_pop);
        w_drop     = w_push_req && w_full && !w_pop;
        w_wr_byte  = {r_hold_q, data};
    end

    // Next-state for pointers, count, nibble pairing and the sticky flag.
    always_comb begin
        w_rd_ptr_d   = r_rd_ptr_q;
        w_wr_ptr_d   = r_wr_ptr_q;
        w_count_d    = r_count_q;
        w_pending_d  = r_pending_q;
        w_overflow_d = r_overflow_q;
        w_hold_d     = r_hold_q;

        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + AW'(1);
        end
        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + AW'(1);
        end
        if (w_push && !w_pop) begin
            w_count_d = r_count_q + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_d = r_count_q - CW'(1);
        end

        if (w_capture) begin
            if (!r_pending_q) begin
                w_hold_d = data;
            end
            w_pending_d = !r_pending_q;
        end

        // Flush and capture target different addresses, so never coincide.
        if (w_flush) begin
            w_pending_d  = 1'b0;
            w_overflow_d = 1'b0;
        end else if (w_drop) begin
            w_overflow_d = 1'b1;
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr_q   <= '0;
            r_wr_ptr_q   <= '0;
            r_count_q    <= '0;
            r_pending_q  <= 1'b0;
            r_overflow_q <= 1'b0;
            r_hold_q     <= 4'h0;
        end else begin
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_count_q    <= w_count_d;
            r_pending_q  <= w_pending_d;
            r_overflow_q <= w_overflow_d;
            r_hold_q     <= w_hold_d;
        end
    end

    // Storage write on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr_q] <= w_wr_byte;
        end
    end

    // Outputs come only from registered state.
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr_q];
    assign pending   = r_pending_q;
    assign full      = w_full;
    assign overflow  = r_overflow_q;
    assign count     = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cscv2_outport.sv
`default_nettype none
// ============================================================================
// Module   : tb_cscv2_outport
// Purpose  : Directed self-checking bench for cscv2_outport.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cscv2_outport;

    localparam int C_CW = 4;

    logic            clk;
    logic            reset_n;
    logic            ramwrite;
    logic [7:0]      address;
    logic [3:0]      data;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_ready;
    logic            pending;
    logic            full;
    logic            overflow;
    logic [C_CW-1:0] count;

    int checks;
    int errors;

    cscv2_outport #(
        .OUT_ADDR   (8'hFF),
        .FLUSH_ADDR (8'hFE),
        .DEPTH      (8),
        .CW         (C_CW)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ramwrite  (ramwrite),
        .address   (address),
        .data      (data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .full      (full),
        .overflow  (overflow),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One core write, sampled 1 ns after the edge that takes it.
    task automatic wr(input logic [7:0] a, input logic [3:0] d);
        ramwrite = 1'b1;
        address  = a;
        data     = d;
        @(posedge clk);
        #1;
        ramwrite = 1'b0;
        address  = 8'h00;
        data     = 4'h0;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        wr(8'hFF, b[7:4]);
        wr(8'hFF, b[3:0]);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"},    32'(count),     32'h0);
        chk({tag, "_valid"},    32'(out_valid), 32'h0);
        chk({tag, "_data"},     32'(out_data),  32'h0);
        chk({tag, "_pending"},  32'(pending),   32'h0);
        chk({tag, "_full"},     32'(full),      32'h0);
        chk({tag, "_overflow"}, 32'(overflow),  32'h0);
    endtask

    logic [7:0] fill_bytes [9];
    logic [7:0] b;

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        ramwrite  = 1'b0;
        address   = 8'h00;
        data      = 4'h0;
        out_ready = 1'b0;
        #2;
        check_reset_state("rst");
        #10;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic nibble pairing
        wr(8'hFF, 4'hA);
        chk("pair_pend1", 32'(pending), 32'h1);
        chk("pair_valid0", 32'(out_valid), 32'h0);
        wr(8'hFF, 4'h5);
        chk("pair_pend0", 32'(pending), 32'h0);
        chk("pair_valid", 32'(out_valid), 32'h1);
        chk("pair_data", 32'(out_data), 32'hA5);
        chk("pair_count", 32'(count), 32'h1);
        pop_one();
        chk("pair_empty", 32'(count), 32'h0);

        // Fill past full; ninth byte is dropped
        fill_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hEE, 8'hF0};
        for (int i = 0; i < 8; i++) wr_byte(fill_bytes[i]);
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_count", 32'(count), 32'h8);
        chk("fill_ovf0", 32'(overflow), 32'h0);
        wr_byte(fill_bytes[8]);
        chk("drop_ovf", 32'(overflow), 32'h1);
        chk("drop_count", 32'(count), 32'h8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_%0d", i), 32'(out_data), 32'(fill_bytes[i]));
            pop_one();
        end
        chk("drain_empty", 32'(out_valid), 32'h0);
        chk("drain_ovf_sticky", 32'(overflow), 32'h1);
        wr(8'hFE, 4'h0);
        chk("flush_ovf", 32'(overflow), 32'h0);

        // Full with simultaneous pop and push
        for (int i = 0; i < 8; i++) wr_byte(8'(8'h10 + i));
        wr(8'hFF, 4'h7);
        out_ready = 1'b1;
        wr(8'hFF, 4'h7);
        out_ready = 1'b0;
        chk("fp_count", 32'(count), 32'h8);
        chk("fp_ovf", 32'(overflow), 32'h0);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("fp_drain_%0d", i), 32'(out_data), 32'(8'h10 + i));
            pop_one();
        end
        chk("fp_last", 32'(out_data), 32'h77);
        pop_one();
        chk("fp_empty", 32'(count), 32'h0);

        // Flush discards a pending nibble; other addresses ignored
        wr(8'hFF, 4'h3);
        chk("fl_pend", 32'(pending), 32'h1);
        wr(8'hFE, 4'hC);
        chk("fl_pend0", 32'(pending), 32'h0);
        wr(8'hFF, 4'h9);
        wr(8'hFF, 4'h1);
        chk("fl_data", 32'(out_data), 32'h91);
        chk("fl_count", 32'(count), 32'h1);
        wr(8'h10, 4'hF);
        chk("ign_count", 32'(count), 32'h1);
        chk("ign_pend", 32'(pending), 32'h0);
        chk("ign_data", 32'(out_data), 32'h91);
        pop_one();

        // Streaming across pointer wrap
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b = 8'(i * 37 + 5);
            wr(8'hFF, b[7:4]);
            chk($sformatf("st_hi_cnt_%0d", i), 32'(count), 32'h0);
            wr(8'hFF, b[3:0]);
            chk($sformatf("st_cnt_%0d", i), 32'(count), 32'h1);
            chk($sformatf("st_data_%0d", i), 32'(out_data), 32'(b));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("st_empty", 32'(count), 32'h0);

        // Asynchronous reset mid-operation
        wr_byte(8'h21);
        wr_byte(8'h43);
        wr_byte(8'h65);
        wr(8'hFF, 4'h8);
        chk("ar_count", 32'(count), 32'h3);
        chk("ar_pend", 32'(pending), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("ar");
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        wr_byte(8'hC4);
        chk("ar_after_count", 32'(count), 32'h1);
        chk("ar_after_data", 32'(out_data), 32'hC4);
        chk("ar_after_pend", 32'(pending), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound on runtime.
    initial begin
        #200000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/cscv2_outport.md
Name: cscv2_outport

Overview:
Memory-mapped output port sitting directly downstream of the CSCv2 core. It snoops the core's RAM write strobe, address and ALU result bus. 4-bit writes to a fixed output address are paired into bytes and buffered in a small FIFO. Bytes are presented on a valid/ready stream for an external consumer such as a UART transmitter or display driver. The core never stalls; lost data is flagged instead.

Parameters:
OUT_ADDR, 8'hFF, RAM address whose writes carry output nibbles
FLUSH_ADDR, 8'hFE, RAM address whose writes discard a pending nibble and clear overflow; must differ from OUT_ADDR (equal values are illegal)
DEPTH, 8, FIFO depth in bytes; power of two, 2..256
CW, 4, count width, equal to log2(DEPTH)+1

Ports:
clk  input  1  system clock, rising-edge active, same clock as the core
reset_n  input  1  asynchronous active-low reset
ramwrite  input  1  core RAM write strobe (RAMwrite)
address  input  8  core RAM address
data  input  4  core ALU result, the data being written
out_data  output  8  head byte of the FIFO
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts out_data this cycle
pending  output  1  high nibble held, waiting for the low nibble
full  output  1  count == DEPTH
overflow  output  1  sticky: a byte was dropped
count  output  CW  bytes currently stored

Behaviour:
- Reset (asynchronous, reset_n low): read/write pointers, count, pending, overflow and the nibble holding register all go to 0. out_valid=0, full=0, out_data=8'h00. Storage contents need not be cleared.
- A reset asserted mid-operation discards all buffered and pending data immediately. Operation resumes on the first rising edge after reset_n goes high.
- Capture: on a rising edge with ramwrite=1 and address==OUT_ADDR:
  - if pending=0, store data in hold[3:0] and set pending=1;
  - if pending=1, form byte {hold,data}, clear pending and issue a push.
- Flush: ramwrite=1 and address==FLUSH_ADDR clears pending and overflow on that edge. FIFO contents are untouched. Writes to any other address are ignored.
- FIFO is first-word-fall-through:
  - out_valid = (count != 0);
  - out_data = entry at the read pointer when out_valid=1, else 8'h00.
- Pop: occurs on a rising edge when out_valid && out_ready. The read pointer advances modulo DEPTH. out_ready while empty has no effect.
- Push: writes at the write pointer, which advances modulo DEPTH. The pointers wrap naturally; full/empty are decided by count, not by pointer comparison.
- Push accepted if count < DEPTH, or if a pop occurs on the same edge (full plus simultaneous pop: both happen, count unchanged).
- Push rejected if count == DEPTH with no pop: the byte is dropped, overflow is set to 1 and stays set until flush or reset. Pointers and count are unchanged.
- Simultaneous push and pop when not full: both happen, count unchanged. When count==0, a push is not popped on the same edge.
- count update: +1 on push only, -1 on pop only, unchanged otherwise.
- Latency: the low-nibble write at edge N makes the byte visible on out_data with out_valid=1 after edge N (FIFO previously empty). This is one cycle of latency.
- Outputs are registered or derived only from registered state. There is no combinational path from ramwrite/address/data to any output. out_ready only affects state at the clock edge.

Test Plan:
- Reset then two writes to 8'hFF with data 4'hA, 4'h5, out_ready=0 -> pending 1 then 0; out_valid=1, out_data=8'hA5, count=1 after the second edge.
- Pairs 12,34,56,...,F0 pushed (9 bytes into DEPTH=8) with out_ready=0 -> full=1 and count=8 after the 8th byte. The 9th byte is dropped and overflow=1. Draining yields 8'h12..8'hEE in order, with no 8'hF0.
- Full FIFO, out_ready=1 held while a new byte 8'h77 completes on the same edge -> count stays 8, overflow stays 0, 8'h77 is emerges last.
- Write 4'h3 to 8'hFF, then write to 8'hFE, then 4'h9, 4'h1 to 8'hFF -> the 3 is discarded, overflow is cleared, the output byte is 8'h91. A write to 8'h10 changes nothing.
- Continuous push/pop with out_ready=1 for 20 bytes -> output order matches input across pointer wrap, and count never exceeds 1.
- reset_n pulsed low asynchronously between clock edges while count=3 and pending=1 -> all outputs go to reset values immediately, and the next pair produces a single correct byte.
